// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential chunk adder.
//   state_t    : controller states (IDLE, BUSY, DONE)
//   calc_n     : number of chunk passes for a given WIDTH/CHUNK
//   cnt_width  : chunk counter width, never less than one bit
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int calc_n(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_fa.sv
// Combinational CHUNK-bit adder shared across all passes of seq_chunk_adder.
//   a_c, b_c  : operand slices
//   ci        : carry in
//   s_c       : slice sum
//   co        : carry out of the top bit
//   c_msb_in  : carry into the top bit (overflow detection)
module chunk_fa #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             ci,
  output logic [CHUNK-1:0] s_c,
  output logic             co,
  output logic             c_msb_in
);

  always_comb begin
    {co, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, ci};
    // Top sum bit is a^b^cin for that position, so the carry into it falls out.
    c_msb_in  = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ s_c[CHUNK-1];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: {carry, sum} = a + b_eff + c_eff, one CHUNK-bit slice per
// clock, LSB slice first, between valid/ready producer and consumer.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid, in_ready    : operand handshake
//   a, b, cin, sub        : operands, carry-in, subtract request
//   out_valid, out_ready  : result handshake
//   sum, carry, overflow  : result, MSB carry-out, signed overflow
// Optional feature: define SEQ_ADDER_SUB_EN to honour sub (b_eff = ~b,
// c_eff = ~cin); otherwise sub is ignored and the block is add-only.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = calc_n(WIDTH, CHUNK);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_nx;
  logic             rdy_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, ovf_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             accept, last;
  int               base;
  logic [CHUNK-1:0] s_c;
  logic             co, c_msb_in;

`ifdef SEQ_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~cin : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_eff      = cin;
`endif

  // rdy_q keeps in_ready low through reset and for the reset edge itself,
  // while still decoding purely from registers.
  assign in_ready  = (state == IDLE) && rdy_q;
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST);
  assign base   = int'(cnt) * CHUNK;

  chunk_fa #(.CHUNK(CHUNK)) u_fa (
    .a_c      (a_q[base +: CHUNK]),
    .b_c      (b_q[base +: CHUNK]),
    .ci       (carry_q),
    .s_c      (s_c),
    .co       (co),
    .c_msb_in (c_msb_in)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdy_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            // carry register is preloaded with c_eff so chunk 0 needs no mux
            carry_q <= c_eff;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
          end
        end
        BUSY: begin
          sum_q[base +: CHUNK] <= s_c;
          carry_q              <= co;
          cnt                  <= cnt + 1'b1;
          if (last) ovf_q <= c_msb_in ^ co;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;

  localparam int W0 = 32;
  localparam int C0 = 4;
  localparam int N0 = W0 / C0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  // 32/4 instance
  logic          in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0;
  logic          carry0, overflow0;
  logic [W0-1:0] a0, b0, sum0;
  // 8/8 instance (N = 1)
  logic          in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1;
  logic          carry1, overflow1;
  logic [7:0]    a1, b1, sum1;

  seq_chunk_adder #(.WIDTH(W0), .CHUNK(C0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin0), .sub(sub0), .out_valid(out_valid0),
    .out_ready(out_ready0), .sum(sum0), .carry(carry0), .overflow(overflow0)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .carry(carry1), .overflow(overflow1)
  );

  int applied = 0;
  int errs    = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] exp_sum;
    logic        exp_carry;
    logic        exp_ovf;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the effective operands.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] be;
    logic        ce;
    logic [32:0] t;
    logic        ovf;
    be = b;
    ce = cin;
`ifdef SEQ_ADDER_SUB_EN
    if (sub) begin
      be = ~b;
      ce = ~cin;
    end
`endif
    t   = {1'b0, a} + {1'b0, be} + {32'd0, ce};
    ovf = (a[31] == be[31]) && (t[31] != a[31]);
    return {ovf, t};
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] es,
                        input logic ec, input logic eo, input bit hold);
    int waited = 0;
    int lat = 0;
    while (!in_ready0 && waited < 50) begin
      tick;
      waited++;
    end
    chk({tag, " in_ready"}, 64'(in_ready0), 64'd1);
    a0 = a; b0 = b; cin0 = cin; sub0 = sub; in_valid0 = 1'b1;
    tick;  // acceptance edge E0
    in_valid0 = 1'b0;
    a0 = $urandom; b0 = $urandom; cin0 = 1'($urandom); sub0 = 1'($urandom);
    while (!out_valid0 && lat < 50) begin
      tick;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(N0));
    chk({tag, " sum"}, 64'(sum0), 64'(es));
    chk({tag, " carry"}, 64'(carry0), 64'(ec));
    chk({tag, " overflow"}, 64'(overflow0), 64'(eo));
    chk({tag, " in_ready in DONE"}, 64'(in_ready0), 64'd0);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        in_valid0 = (i % 2 == 0);
        a0 = $urandom;
        b0 = $urandom;
        tick;
        chk({tag, " hold out_valid"}, 64'(out_valid0), 64'd1);
        chk({tag, " hold in_ready"}, 64'(in_ready0), 64'd0);
        chk({tag, " hold sum"}, 64'(sum0), 64'(es));
        chk({tag, " hold carry"}, 64'(carry0), 64'(ec));
      end
      in_valid0 = 1'b0;
    end
    out_ready0 = 1'b1;
    tick;
    out_ready0 = 1'b0;
    chk({tag, " out_valid drop"}, 64'(out_valid0), 64'd0);
    chk({tag, " in_ready back"}, 64'(in_ready0), 64'd1);
  endtask

  vec_t vecs[6];
  int   acc_cyc[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h8000_0001, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
`ifdef SEQ_ADDER_SUB_EN
    vecs[5] = '{32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
`else
    vecs[5] = '{32'd5, 32'd7, 1'b0, 1'b1, 32'd12, 1'b0, 1'b0};
`endif

    rst_n = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    tick;
    tick;
    chk("reset in_ready", 64'(in_ready0), 64'd0);
    chk("reset out_valid", 64'(out_valid0), 64'd0);
    chk("reset sum", 64'(sum0), 64'd0);
    chk("reset carry", 64'(carry0), 64'd0);
    chk("reset overflow", 64'(overflow0), 64'd0);
    chk("reset in_ready n1", 64'(in_ready1), 64'd0);
    rst_n = 1'b1;
    tick;
    chk("release in_ready", 64'(in_ready0), 64'd1);

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].exp_sum, vecs[i].exp_carry, vecs[i].exp_ovf, i == 0);

    // Reset during BUSY abandons the operation.
    a0 = 32'hDEAD_BEEF; b0 = 32'h1; cin0 = 1'b0; in_valid0 = 1'b1;
    tick;  // E0
    in_valid0 = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    tick;  // reset edge at E0+3
    chk("midreset out_valid", 64'(out_valid0), 64'd0);
    chk("midreset in_ready", 64'(in_ready0), 64'd0);
    rst_n = 1'b1;
    tick;
    chk("post-reset in_ready", 64'(in_ready0), 64'd1);
    for (int i = 0; i < N0 + 2; i++) begin
      chk("abandoned out_valid", 64'(out_valid0), 64'd0);
      tick;
    end
    run_op("after reset", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

    // Randomized against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      logic        rc, rs;
      logic [33:0] m;
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      if (i % 4 == 0) ra = {ra[31], 31'h7FFF_FFFF};
      m = model(ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, m[31:0], m[32], m[33], 1'b0);
    end

    // N = 1 instance: single BUSY cycle.
    a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0; in_valid1 = 1'b1;
    tick;  // E0
    in_valid1 = 1'b0;
    chk("n1 busy out_valid", 64'(out_valid1), 64'd0);
    tick;  // E0+1
    chk("n1 out_valid", 64'(out_valid1), 64'd1);
    chk("n1 sum", 64'(sum1), 64'h00);
    chk("n1 carry", 64'(carry1), 64'd1);
    chk("n1 overflow", 64'(overflow1), 64'd1);
    tick;

    // Back-to-back with out_ready tied high: one accept every 3 cycles.
    in_valid1 = 1'b1;
    for (int c = 0; c < 13; c++) begin
      logic acc;
      acc = in_valid1 && in_ready1;
      tick;
      if (acc) begin
        acc_cyc.push_back(c);
        a1 = 8'($urandom);
      end
    end
    in_valid1 = 1'b0;
    chk("n1 accept count", 64'(acc_cyc.size() >= 4), 64'd1);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("n1 accept gap%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule
